balance_db_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that lets several ATM front-end controllers share one balance database. Each requester presents an account index, an operation and an amount. The block serialises these into atomic read-modify-write transactions against a single-port memory. It sits between the per-terminal ATM FSMs and the balance storage, and is the only writer of that storage.

---
 rtl/balance_db_arbiter.sv | 155 +++++++++++++++
 tb/tb_balance_db_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/balance_db_arbiter.sv
// rtl/balance_db_arbiter.sv - round-robin arbiter serialising atomic balance read-modify-write transactions
// Optional withdraw limit: define DB_ARB_WD_LIMIT_EN.
module balance_db_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ACC_W        = 4,
    parameter int NUM_ACC      = 10,
    parameter int BAL_W        = 32,
    parameter int MAX_WITHDRAW = 5000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [ACC_W*NUM_REQ-1:0] req_acc,
    input  logic [BAL_W*NUM_REQ-1:0] req_amt,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     ok,
    output logic [BAL_W-1:0]         resp_bal,
    output logic                     db_re,
    output logic [ACC_W-1:0]         db_addr,
    input  logic [BAL_W-1:0]         db_rdata,
    output logic                     db_we,
    output logic [BAL_W-1:0]         db_wdata
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef DB_ARB_WD_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif
    // With the limit disabled the ceiling is all-ones, so only the funds check can fail.
    localparam logic [BAL_W-1:0] WD_LIMIT = LIMIT_EN ? BAL_W'(MAX_WITHDRAW) : {BAL_W{1'b1}};

    typedef enum logic [1:0] {IDLE, READ, EXEC, RESP} state_t;

    state_t            state;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     owner;
    logic [1:0]        op_q;
    logic [ACC_W-1:0]  acc_q;
    logic [BAL_W-1:0]  amt_q;
    logic              bad_q;

    logic              sel_valid;
    logic [PW-1:0]     sel_idx;
    logic [1:0]        sel_op;
    logic [ACC_W-1:0]  sel_acc;
    logic [BAL_W-1:0]  sel_amt;
    int                j;

    // Walk from farthest to nearest offset so the requester closest after rr_ptr wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_op    = '0;
        sel_acc   = '0;
        sel_amt   = '0;
        j         = 0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            j = (int'(rr_ptr) + off) % NUM_REQ;
            if (req[j]) begin
                sel_valid = 1'b1;
                sel_idx   = PW'(j);
                sel_op    = req_op[2*j +: 2];
                sel_acc   = req_acc[ACC_W*j +: ACC_W];
                sel_amt   = req_amt[BAL_W*j +: BAL_W];
            end
        end
    end

    logic [BAL_W:0]    sum;
    logic              ex_ok;
    logic              ex_write;
    logic [BAL_W-1:0]  ex_new;

    assign sum = {1'b0, db_rdata} + {1'b0, amt_q};

    always_comb begin
        ex_ok    = 1'b0;
        ex_write = 1'b0;
        ex_new   = db_rdata;
        if (!bad_q) begin
            case (op_q)
                2'b00: ex_ok = 1'b1;
                2'b01: begin
                    if (!sum[BAL_W]) begin
                        ex_ok    = 1'b1;
                        ex_write = 1'b1;
                        ex_new   = sum[BAL_W-1:0];
                    end
                end
                2'b10: begin
                    if (amt_q <= WD_LIMIT && amt_q <= db_rdata) begin
                        ex_ok    = 1'b1;
                        ex_write = 1'b1;
                        ex_new   = db_rdata - amt_q;
                    end
                end
                default: ex_ok = 1'b0;
            endcase
        end
    end

    assign db_re    = (state == READ) && !bad_q;
    assign db_addr  = (state == READ || state == EXEC) ? acc_q : '0;
    assign db_we    = (state == EXEC) && ex_write;
    assign db_wdata = db_we ? ex_new : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rr_ptr   <= PW'(NUM_REQ - 1);
            owner    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            amt_q    <= '0;
            bad_q    <= 1'b0;
            grant    <= '0;
            done     <= '0;
            ok       <= 1'b0;
            resp_bal <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        owner <= sel_idx;
                        op_q  <= sel_op;
                        acc_q <= sel_acc;
                        amt_q <= sel_amt;
                        // Reserved ops are rejected up front, like bad accounts, without touching memory.
                        bad_q <= (int'(sel_acc) >= NUM_ACC) || (sel_op == 2'b11);
                        grant <= NUM_REQ'(1) << sel_idx;
                        state <= READ;
                    end
                end
                READ: state <= EXEC;
                EXEC: begin
                    done     <= NUM_REQ'(1) << owner;
                    ok       <= ex_ok;
                    resp_bal <= bad_q ? '0 : ex_new;
                    state    <= RESP;
                end
                default: begin
                    done     <= '0;
                    ok       <= 1'b0;
                    resp_bal <= '0;
                    grant    <= '0;
                    rr_ptr   <= owner;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_balance_db_arbiter.sv
// tb/tb_balance_db_arbiter.sv - directed and randomized bench for balance_db_arbiter with a behavioural balance model
module tb_balance_db_arbiter;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  req = '0;
    logic [2*N-1:0]  req_op = '0;
    logic [4*N-1:0]  req_acc = '0;
    logic [32*N-1:0] req_amt = '0;
    logic [N-1:0]  grant, done;
    logic          ok, db_re, db_we;
    logic [31:0]   resp_bal, db_wdata;
    logic [31:0]   db_rdata = '0;
    logic [3:0]    db_addr;

    logic [31:0]   mem [16];
    logic [31:0]   init_vals [16];
    logic          load = 1'b0;
    longint        ref_bal [10];
    int            model_ptr = N - 1;
    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;

    balance_db_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_acc(req_acc), .req_amt(req_amt),
        .grant(grant), .done(done), .ok(ok), .resp_bal(resp_bal),
        .db_re(db_re), .db_addr(db_addr), .db_rdata(db_rdata), .db_we(db_we), .db_wdata(db_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_vals[i];
        end else begin
            if (db_we) mem[db_addr] <= db_wdata;
            if (db_re) db_rdata <= mem[db_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: what the balance store should do, from the account rules alone.
    task automatic model(input int op, input int acc, input longint amt,
                         output bit re, output bit we, output bit okx, output longint resp);
        longint old;
        re = 0; we = 0; okx = 0; resp = 0;
        if (acc < 10 && op != 3) begin
            re = 1;
            old = ref_bal[acc];
            resp = old;
            if (op == 0) okx = 1;
            else if (op == 1) begin
                if (old + amt <= 64'hFFFF_FFFF) begin okx = 1; we = 1; resp = old + amt; end
            end else begin
`ifdef DB_ARB_WD_LIMIT_EN
                if (amt <= 5000 && amt <= old) begin okx = 1; we = 1; resp = old - amt; end
`else
                if (amt <= old) begin okx = 1; we = 1; resp = old - amt; end
`endif
            end
            if (we) ref_bal[acc] = resp;
        end
    endtask

    task automatic set_req(input int idx, input int op, input int acc, input longint amt);
        logic [1:0]  o;
        logic [3:0]  a;
        logic [31:0] m;
        o = 2'(op); a = 4'(acc); m = 32'(amt);
        req_op[2*idx +: 2]   = o;
        req_acc[4*idx +: 4]  = a;
        req_amt[32*idx +: 32] = m;
        req[idx] = 1'b1;
    endtask

    task automatic run_single(input int idx, input int op, input int acc, input longint amt);
        bit re, we, okx;
        longint resp;
        logic [N-1:0] oh;
        model(op, acc, amt, re, we, okx, resp);
        oh = 4'b0001 << idx;
        @(negedge clk);
        set_req(idx, op, acc, amt);
        @(posedge clk); #1;
        chk("grant", grant, oh);
        chk("db_re", db_re, re);
        if (re) chk("db_addr", db_addr, acc);
        chk("db_we_read", db_we, 0);
        @(posedge clk); #1;
        chk("db_we", db_we, we);
        if (we) chk("db_wdata", db_wdata, resp);
        chk("db_re_exec", db_re, 0);
        @(posedge clk); #1;
        chk("done", done, oh);
        chk("ok", ok, okx);
        chk("resp_bal", resp_bal, resp);
        chk("db_we_resp", db_we, 0);
        req[idx] = 1'b0;
        @(posedge clk); #1;
        chk("grant_clr", grant, 0);
        chk("done_clr", done, 0);
        model_ptr = idx;
    endtask

    task automatic run_held(input logic [N-1:0] mask, input int n);
        int last_cyc, waited, p;
        logic [N-1:0] exp;
        last_cyc = 0;
        @(negedge clk);
        for (int i = 0; i < N; i++) if (mask[i]) set_req(i, 0, i + 1, 0);
        for (int t = 0; t < n; t++) begin
            waited = 0;
            do begin
                @(posedge clk); #1;
                waited++;
                chk("grant_onehot0", $onehot0(grant), 1);
            end while (grant == 0 && waited < 10);
            p = (model_ptr + 1) % N;
            while (!mask[p]) p = (p + 1) % N;
            exp = 4'b0001 << p;
            chk("rr_grant", grant, exp);
            if (t > 0) chk("rr_spacing", cyc - last_cyc, 4);
            last_cyc = cyc;
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk("rr_done", done, exp);
            chk("rr_ok", ok, 1);
            chk("rr_bal", resp_bal, ref_bal[p + 1]);
            model_ptr = p;
            if (t == n - 1) req = '0;
        end
        @(posedge clk); #1;
        chk("rr_end_grant", grant, 0);
        chk("rr_end_done", done, 0);
    endtask

    initial begin
        int idx, op, acc;
        longint amt;
        logic [31:0] saved;
        for (int i = 0; i < 10; i++) ref_bal[i] = longint'($urandom_range(0, 100000));
        ref_bal[3] = 1000;
        ref_bal[5] = 64'hFFFF_FFFF;
        ref_bal[7] = 9000;
        for (int i = 0; i < 16; i++) init_vals[i] = (i < 10) ? 32'(ref_bal[i]) : 32'd0;
        load = 1'b1;
        repeat (3) @(posedge clk);
        load = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_ok", ok, 0);
        chk("rst_resp", resp_bal, 0);
        chk("rst_mem_if", {db_re, db_we, db_addr, db_wdata}, 0);

        run_single(0, 0, 3, 0);
        run_single(1, 1, 3, 250);
        run_single(1, 2, 3, 2000);
        run_single(2, 1, 5, 1);
        run_single(3, 2, 3, 0);
        run_held(4'b1111, 5);
        run_single(0, 0, 12, 0);
        run_single(1, 3, 3, 5);
        run_single(2, 2, 7, 6000);
        run_single(3, 2, 7, 5000);

        for (int t = 0; t < 40; t++) begin
            idx = $urandom_range(0, N - 1);
            op  = $urandom_range(0, 7) == 0 ? 3 : $urandom_range(0, 2);
            acc = $urandom_range(0, 11);
            if ($urandom_range(0, 1) == 1 && acc < 10) amt = ref_bal[acc];
            else amt = longint'($urandom_range(0, 200000));
            run_single(idx, op, acc, amt);
        end

        saved = mem[4];
        @(negedge clk);
        set_req(2, 1, 4, 100);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_we_pre", db_we, 1);
        rst = 1'b0;
        req = '0;
        #1;
        chk("abort_outs", {grant, done, ok, resp_bal, db_re, db_we, db_addr, db_wdata}, 0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("abort_no_done", done, 0);
        end
        chk("abort_mem", mem[4], saved);
        @(negedge clk);
        rst = 1'b1;
        model_ptr = N - 1;
        run_held(4'b0011, 2);
        run_single(3, 0, 4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
